// File: rtl/ads127l01_pkg.sv
// Shared types and helpers for the ADS127L01 acquisition controller.
//   acq_state_t : sequencer states
//   ADC_W       : native ADC word width
//   sext32()    : sign-extend the low 'width' bits of a word to 32 bits
package ads127l01_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        WAKE,
        RUN,
        FAULT
    } acq_state_t;

    localparam int unsigned ADC_W = 24;

    // Shift the sign bit up to bit 31, then arithmetic-shift back down.
    function automatic logic [31:0] sext32(input logic [31:0] w, input int unsigned width);
        logic [4:0] sh;
        sh = 5'(32 - width);
        return 32'($signed(w << sh) >>> sh);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and flush.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : empties the FIFO (wins over push/pop)
//   wr_en/wr_data: push request; accepted when not full or when popping in the same cycle
//   rd_en        : pop request; ignored when empty
//   rd_data_c    : head word (undefined content when empty)
//   count        : words held, saturates at DEPTH
//   full_c/empty_c: occupancy flags decoded from count
module sync_fifo #(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign rd_data_c = mem[rd_ptr];

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign do_pop  = rd_en & ~empty_c;
    assign do_push = wr_en & (~full_c | do_pop);

    // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/ads127l01_acq_ctrl.sv
// Sequencer and capture controller for one ADS127L01 in frame-sync master mode.
// Brings the ADC out of reset from a GPIO enable, deserialises DATA_W-bit frames
// clocked by the ADC's own sck and buffers them for an AXI-lite register slice.
// Ports:
//   aclk, aresetn      : system clock, asynchronous active-low reset
//   enable             : level-sensitive run request
//   sck, dout, fsync   : ADC serial interface (asynchronous to aclk)
//   adc_reset_n        : ADC reset_n pin
//   adc_start          : ADC start pin
//   rd_en              : pop one word from the buffer
//   rd_data            : sign-extended head word, 0 when empty
//   data_cnt           : words held
//   overflow           : sticky, a completed frame was dropped on a full buffer
//   timeout            : high while the frame-sync watchdog has tripped
module ads127l01_acq_ctrl
    import ads127l01_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RST_CYCLES = 100,
    parameter int unsigned START_DLY  = 50,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          sck,
    input  logic                          dout,
    input  logic                          fsync,
    output logic                          adc_reset_n,
    output logic                          adc_start,
    input  logic                          rd_en,
    output logic [31:0]                   rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   data_cnt,
    output logic                          overflow,
    output logic                          timeout
);

    localparam int unsigned PH_MAX = (RST_CYCLES > START_DLY) ? RST_CYCLES : START_DLY;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    acq_state_t        state;
    acq_state_t        state_next;
    logic [PH_W-1:0]   phase_cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic [2:0]        sck_sh;
    logic [2:0]        fsync_sh;
    logic [1:0]        dout_sh;
    logic              dout_q;
    logic              sck_rise;
    logic              fsync_rise;

    logic              armed;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              push;

    logic              flush_c;
    logic [DATA_W-1:0] head_c;
    logic              full_c;
    logic              empty_c;

    // Two sync stages, a third stage for edge detection; dout is delayed to line up
    // with the registered sck edge so the sampled bit matches the edge that flagged it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sck_sh     <= '0;
            fsync_sh   <= '0;
            dout_sh    <= '0;
            dout_q     <= 1'b0;
            sck_rise   <= 1'b0;
            fsync_rise <= 1'b0;
        end else begin
            sck_sh     <= {sck_sh[1:0], sck};
            fsync_sh   <= {fsync_sh[1:0], fsync};
            dout_sh    <= {dout_sh[0], dout};
            dout_q     <= dout_sh[1];
            sck_rise   <= sck_sh[1] & ~sck_sh[2];
            fsync_rise <= fsync_sh[1] & ~fsync_sh[2];
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        flush_c    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RESET;
                    flush_c    = 1'b1;
                end
            end
            RESET: begin
                if (phase_cnt == PH_W'(RST_CYCLES - 1)) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                if (phase_cnt == PH_W'(START_DLY - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!fsync_rise && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    // Dwell counter for RESET/WAKE, restarted on every state change.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_cnt <= '0;
        end else if ((state_next != state) || ((state != RESET) && (state != WAKE))) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
        end
    end

    // Frame-sync watchdog, live only in RUN.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt <= '0;
        end else if ((state != RUN) || fsync_rise) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Pin and status outputs registered from the next state so they track the state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            adc_reset_n <= 1'b0;
            adc_start   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            adc_reset_n <= (state_next == WAKE) || (state_next == RUN) || (state_next == FAULT);
            adc_start   <= (state_next == RUN);
            timeout     <= (state_next == FAULT);
        end
    end

    // Deserialiser: fsync re-arms (discarding any partial word), DATA_W sck edges fill it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            armed   <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            push    <= 1'b0;
        end else if (state != RUN) begin
            armed   <= 1'b0;
            bit_cnt <= '0;
            push    <= 1'b0;
        end else begin
            push <= 1'b0;
            if (fsync_rise) begin
                armed   <= 1'b1;
                bit_cnt <= '0;
            end else if (armed && sck_rise) begin
                shreg <= {shreg[DATA_W-2:0], dout_q};
                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                    armed   <= 1'b0;
                    bit_cnt <= '0;
                    push    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    // Sticky drop flag; a simultaneous pop frees the slot so that push is not a drop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow <= 1'b0;
        end else if (flush_c) begin
            overflow <= 1'b0;
        end else if (push && full_c && !rd_en) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .flush     (flush_c),
        .wr_en     (push),
        .wr_data   (shreg),
        .rd_en     (rd_en),
        .rd_data_c (head_c),
        .count     (data_cnt),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    assign rd_data = empty_c ? 32'h0 : sext32(32'(head_c), DATA_W);

endmodule

// File: tb/tb_ads127l01_acq_ctrl.sv
// Bench for ads127l01_acq_ctrl: bring-up timing, frame capture, FIFO corner cases,
// watchdog fault and mid-frame reset, against a queue-based model of the buffer.
module tb_ads127l01_acq_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        sck;
    logic        dout;
    logic        fsync;
    logic        rd_en;
    logic        adc_reset_n;
    logic        adc_start;
    logic [31:0] rd_data;
    logic [4:0]  data_cnt;
    logic        overflow;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    logic [23:0] mq[$];
    bit          ovf_m;

    typedef struct {
        logic [23:0] w;
        logic [31:0] sx;
    } vec_t;

    vec_t        vecs[6];
    logic [23:0] words[17];
    logic [23:0] rw;

    always #5 aclk = ~aclk;

    ads127l01_acq_ctrl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .enable      (enable),
        .sck         (sck),
        .dout        (dout),
        .fsync       (fsync),
        .adc_reset_n (adc_reset_n),
        .adc_start   (adc_start),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .data_cnt    (data_cnt),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_head();
        logic [23:0] h;
        if (mq.size() == 0) return 32'h0;
        h = mq[0];
        return {{8{h[23]}}, h};
    endfunction

    task automatic check_fifo(input string tag);
        check({tag, "/cnt"}, 32'(data_cnt), 32'(mq.size()));
        check({tag, "/rd"},  rd_data, model_head());
        check({tag, "/ovf"}, 32'(overflow), 32'(ovf_m));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // ADC model: fsync pulse, then nbits MSB-first bits, dout set while sck low.
    task automatic send_frame(input logic [23:0] w, input int nbits, input bit pop_last);
        fsync = 1'b1;
        tick(4);
        fsync = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            dout = w[23-i];
            tick(3);
            sck = 1'b1;
            if (pop_last && (i == nbits - 1)) begin
                tick(4);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end else begin
                tick(3);
            end
            sck = 1'b0;
        end
        tick(8);
        if (nbits == 24) begin
            if (pop_last && (mq.size() > 0)) mq.delete(0);
            if (mq.size() < 16) mq.push_back(w);
            else ovf_m = 1'b1;
        end
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (mq.size() > 0) mq.delete(0);
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!adc_start && (n < 400)) begin
            tick(1);
            n++;
        end
        check({tag, "/start_seen"}, 32'(adc_start), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/rstn"},  32'(adc_reset_n), 32'd0);
        check({tag, "/start"}, 32'(adc_start),   32'd0);
        check({tag, "/rd"},    rd_data,          32'h0);
        check({tag, "/cnt"},   32'(data_cnt),    32'd0);
        check({tag, "/ovf"},   32'(overflow),    32'd0);
        check({tag, "/tmo"},   32'(timeout),     32'd0);
    endtask

    initial begin
        int lo_cnt;
        int wake_cnt;
        int r;

        vecs[0] = '{24'h123456, 32'h00123456};
        vecs[1] = '{24'hFEDCBA, 32'hFFFEDCBA};
        vecs[2] = '{24'h800000, 32'hFF800000};
        vecs[3] = '{24'h7FFFFF, 32'h007FFFFF};
        vecs[4] = '{24'h000000, 32'h00000000};
        vecs[5] = '{24'hFFFFFF, 32'hFFFFFFFF};

        aresetn = 1'b0;
        enable  = 1'b0;
        sck     = 1'b0;
        dout    = 1'b0;
        fsync   = 1'b0;
        rd_en   = 1'b0;
        ovf_m   = 1'b0;
        tick(3);
        check_reset_vals("por");
        aresetn = 1'b1;
        tick(2);

        // Bring-up timing: reset_n low 100 cycles, then 50 cycles before start.
        enable   = 1'b1;
        lo_cnt   = 0;
        wake_cnt = 0;
        for (int i = 0; (i < 400) && !adc_start; i++) begin
            tick(1);
            if (!adc_reset_n) lo_cnt++;
            else if (!adc_start) wake_cnt++;
        end
        check("bringup/reset_low", 32'(lo_cnt), 32'd100);
        check("bringup/wake", 32'(wake_cnt), 32'd50);
        check("bringup/start", 32'(adc_start), 32'd1);

        // Two frames, pop them back out.
        send_frame(24'h123456, 24, 1'b0);
        send_frame(24'hFEDCBA, 24, 1'b0);
        check("two/cnt", 32'(data_cnt), 32'd2);
        check("two/rd0", rd_data, 32'h00123456);
        pop();
        check("two/rd1", rd_data, 32'hFFFEDCBA);
        pop();
        check("two/cnt_empty", 32'(data_cnt), 32'd0);
        check("two/rd_empty", rd_data, 32'h0);
        pop();
        check("pop_empty/cnt", 32'(data_cnt), 32'd0);
        check("pop_empty/rd", rd_data, 32'h0);

        // Sign-extension table.
        foreach (vecs[k]) begin
            send_frame(vecs[k].w, 24, 1'b0);
            check($sformatf("sext%0d/rd", k), rd_data, vecs[k].sx);
            check($sformatf("sext%0d/cnt", k), 32'(data_cnt), 32'd1);
            pop();
            check($sformatf("sext%0d/cnt0", k), 32'(data_cnt), 32'd0);
        end

        // 17 frames into a 16-deep buffer.
        for (int k = 0; k < 17; k++) begin
            words[k] = 24'($urandom);
            send_frame(words[k], 24, 1'b0);
        end
        check("full/cnt", 32'(data_cnt), 32'd16);
        check("full/ovf", 32'(overflow), 32'd1);
        for (int k = 0; k < 16; k++) begin
            rw = words[k];
            check($sformatf("full/word%0d", k), rd_data, {{8{rw[23]}}, rw});
            pop();
        end
        check("full/drained", 32'(data_cnt), 32'd0);
        check("full/ovf_sticky", 32'(overflow), 32'd1);

        // Pop coinciding with the push at count 3.
        for (int k = 0; k < 3; k++) send_frame(24'($urandom), 24, 1'b0);
        check_fifo("pp/pre");
        send_frame(24'hABCDEF, 24, 1'b1);
        check("pp/cnt", 32'(data_cnt), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check_fifo($sformatf("pp/order%0d", k));
            pop();
        end
        check_fifo("pp/end");

        // Random frames, restarted partial frames and pops.
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                send_frame(24'($urandom), 24, 1'b0);
            end else if (r < 7) begin
                send_frame(24'($urandom), int'($urandom_range(1, 23)), 1'b0);
                send_frame(24'($urandom), 24, 1'b0);
            end else begin
                repeat ($urandom_range(1, 3)) pop();
            end
            check_fifo($sformatf("rnd%0d", it));
        end

        // Watchdog: stop fsync in RUN.
        send_frame(24'h5A5A5A, 24, 1'b0);
        tick(3800);
        check("wd/early_tmo", 32'(timeout), 32'd0);
        check("wd/early_start", 32'(adc_start), 32'd1);
        tick(300);
        check("wd/tmo", 32'(timeout), 32'd1);
        check("wd/start", 32'(adc_start), 32'd0);
        check("wd/rstn", 32'(adc_reset_n), 32'd1);
        enable = 1'b0;
        tick(2);
        check("wd_off/rstn", 32'(adc_reset_n), 32'd0);
        check("wd_off/tmo", 32'(timeout), 32'd0);
        check_fifo("wd_off/kept");

        // Re-enable flushes; then reset mid-frame.
        enable = 1'b1;
        mq.delete();
        ovf_m = 1'b0;
        wait_run("reen");
        check_fifo("reen");
        send_frame(24'h0F0F0F, 24, 1'b0);
        send_frame(24'h333333, 10, 1'b0);
        aresetn = 1'b0;
        #1;
        check_reset_vals("midrst");
        enable = 1'b0;
        tick(2);
        aresetn = 1'b1;
        mq.delete();
        tick(2);
        enable = 1'b1;
        wait_run("after_rst");
        send_frame(24'hA5C3E1, 24, 1'b0);
        check("after_rst/cnt", 32'(data_cnt), 32'd1);
        check("after_rst/rd", rd_data, 32'hFFA5C3E1);
        check("after_rst/ovf", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
